tdm_slot_scheduler: RTL and testbench
=====================================

// Module: tdm_slot_scheduler
// PURPOSE
//  Upstream driver for the 1-to-4 demultiplexer stage (data iC, selects iS1/iS0, unselected outputs idle 1).
//  Accepts a 4-channel frame (data bits plus channel mask) over a valid/ready handshake.
//  Time-division scans the enabled channels in ascending order, presenting each for HOLD_CYCLES cycles on oC/oS1/oS0.
//  Returns oC to idle 1 between frames.
// PARAMETERS
//  HOLD_CYCLES  4  cycles each enabled channel is held on the bus; legal range 1..255
// PORTS
//  iClk    in   1  single clock; all logic on the rising edge
//  iRst    in   1  synchronous, active-high reset
//  iValid  in   1  frame offered on iData/iMask
//  oReady  out  1  scheduler can accept a frame; transfer occurs on iValid & oReady at a rising edge
//  iData   in   4  per-channel level; bit n goes to demux output n
//  iMask   in   4  per-channel enable; 0 = skip that channel
//  oC      out  1  data to demux iC; idle 1
//  oS1     out  1  channel select MSB, to demux iS1
//  oS0     out  1  channel select LSB, to demux iS0
//  oBusy   out  1  frame in progress
//  oDone   out  1  one-cycle pulse at end of frame
// BEHAVIOUR
//  - Reset values, applied at the first edge with iRst=1 from any state, including mid-frame:
//    state IDLE, oReady=1, oC=1, {oS1,oS0}=00, oBusy=0, oDone=0, latched frame cleared.
//  - All outputs are registered. iData and iMask are captured only on the accept edge.
//    Changes to them while busy are ignored.
//  - State IDLE: oReady=1, outputs at idle values.
//    - Accept with iMask != 0: go to SLOT on the lowest set bit.
//    - Accept with iMask == 0: go to DONE directly; no slot is produced and select never changes.
//  - State SLOT(ch):
//    - Outputs: {oS1,oS0}=ch, oC=data[ch], oBusy=1, oReady=0.
//    - The slot lasts exactly HOLD_CYCLES cycles, counted by the slot timer.
//    - On the last cycle, move to the next higher set mask bit; if none remains, go to DONE.
//  - State DONE, one cycle: oC=1, {oS1,oS0}=00, oBusy=0, oDone=1, oReady=1.
//    - An accept in this cycle is legal; its first slot appears on the next cycle with no idle gap.
//    - With no accept, return to IDLE.
//  - Latency: accept at edge k puts the first slot on the outputs from cycle k+1.
//  - Frame length = popcount(iMask)*HOLD_CYCLES cycles, plus guard cycles (see CONFIGURATION), plus 1 DONE cycle.
//  - iValid while busy: no transfer, no effect. A frame is never aborted except by iRst.
//  - Select is updated in the same cycle that oC takes the new channel's data.
//    Both come from one register update, so there is no skew between them.
// CONFIGURATION
//  - Macro TDM_GUARD_EN defined:
//    - Between consecutive slots, insert one GUARD cycle.
//    - In the GUARD cycle, oC=1 and {oS1,oS0} already equal the next channel, so the demux switches while its data is idle.
//    - No guard cycle before the first slot or after the last slot.
//  - Macro TDM_GUARD_EN undefined: slots are back-to-back and the GUARD state is not built.
// STRUCTURE
//  - Package tdm_pkg:
//    - NUM_CH=4, CH_W=2
//    - state enum {IDLE, SLOT, GUARD, DONE}
//    - function next_ch(mask, ch): returns the next set bit above ch, or a none flag
//  - Sub-module tdm_slot_timer:
//    - Down-counter of width $clog2(HOLD_CYCLES+1).
//    - Reloads on slot start; asserts a last flag when the count reaches 1.
//    - Cleared by iRst.
//  - Top level holds the FSM, the frame latch and the output registers.
// TESTING
//  - Reset mid-frame: assert iRst for 1 cycle during the ch1 slot
//    -> next cycle oC=1, sel=00, oBusy=0, oReady=1, oDone=0.
//  - Full frame, iData=4'b1010, iMask=4'b1111, HOLD=4
//    -> slots in order: sel00/oC=0, sel01/oC=1, sel10/oC=0, sel11/oC=1, 4 cycles each
//    -> oDone pulses on cycle 17 after accept.
//  - Sparse mask, iMask=4'b0100, iData=4'b0000 -> sel=10 with oC=0 for 4 cycles, then DONE; sel never shows 00 with oC=0.
//  - Empty mask, iMask=0 -> oDone=1 the cycle after accept; oC stays 1, sel stays 00, oBusy stays 0.
//  - Back-to-back: iValid held high with two frames, iMask=0001 each
//    -> second slot starts the cycle after oDone; only one idle (DONE) cycle between slots.
//  - With TDM_GUARD_EN, iMask=4'b0011, iData=4'b0000
//    -> sel00/oC=0 x4, then guard sel01/oC=1 x1, then sel01/oC=0 x4, then DONE.

Source files
------------

// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and channel-search helpers for the TDM slot scheduler
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic [1:0] {
    IDLE,
    SLOT,
    GUARD,
    DONE
  } state_t;

  // found=0 is the "none" flag; ch is only meaningful when found=1
  typedef struct packed {
    logic            found;
    logic [CH_W-1:0] ch;
  } ch_pick_t;

  function automatic ch_pick_t first_ch(input logic [NUM_CH-1:0] mask);
    ch_pick_t r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        r.found = 1'b1;
        r.ch    = CH_W'(i);
      end
    end
    return r;
  endfunction

  function automatic ch_pick_t next_ch(input logic [NUM_CH-1:0] mask,
                                       input logic [CH_W-1:0]   ch);
    ch_pick_t r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(ch))) begin
        r.found = 1'b1;
        r.ch    = CH_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tdm_slot_timer.sv
// rtl/tdm_slot_timer.sv - per-slot down-counter; oLast marks the final cycle of a slot
module tdm_slot_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iStart,
  output logic oLast
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Counter parks at zero between slots so oLast cannot fire outside a slot
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_cnt <= '0;
    end else if (iStart) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  assign oLast = (r_cnt == ONE);

endmodule

// File: rtl/tdm_slot_scheduler.sv
// rtl/tdm_slot_scheduler.sv - time-division driver for a 1-to-4 demux (data oC, select oS1/oS0)
// Define TDM_GUARD_EN to insert one idle-data guard cycle between consecutive slots.
module tdm_slot_scheduler
  import tdm_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iValid,
  output logic              oReady,
  input  logic [NUM_CH-1:0] iData,
  input  logic [NUM_CH-1:0] iMask,
  output logic              oC,
  output logic              oS1,
  output logic              oS0,
  output logic              oBusy,
  output logic              oDone
);

  state_t            r_state;
  logic [CH_W-1:0]   r_ch;
  logic [NUM_CH-1:0] r_data;
  logic [NUM_CH-1:0] r_mask;
  logic              r_c;
  logic [CH_W-1:0]   r_sel;
  logic              r_busy;
  logic              r_done;
  logic              r_ready;

  state_t            w_state_nxt;
  logic [CH_W-1:0]   w_ch_nxt;
  logic [NUM_CH-1:0] w_data_nxt;
  logic [NUM_CH-1:0] w_mask_nxt;
  logic              w_c_nxt;
  logic [CH_W-1:0]   w_sel_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_ready_nxt;
  logic              w_tmr_start;
  logic              w_tmr_last;
  logic              w_accept;
  ch_pick_t          w_pick_first;
  ch_pick_t          w_pick_next;

  assign w_accept     = iValid & r_ready;
  assign w_pick_first = first_ch(iMask);
  assign w_pick_next  = next_ch(r_mask, r_ch);

  tdm_slot_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_slot_timer (
    .iClk  (iClk),
    .iRst  (iRst),
    .iStart(w_tmr_start),
    .oLast (w_tmr_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_data_nxt  = r_data;
    w_mask_nxt  = r_mask;
    w_tmr_start = 1'b0;

    case (r_state)
      IDLE, DONE: begin
        w_state_nxt = IDLE;
        if (w_accept) begin
          w_data_nxt = iData;
          w_mask_nxt = iMask;
          if (w_pick_first.found) begin
            w_state_nxt = SLOT;
            w_ch_nxt    = w_pick_first.ch;
            w_tmr_start = 1'b1;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      SLOT: begin
        if (w_tmr_last) begin
          if (w_pick_next.found) begin
            w_ch_nxt = w_pick_next.ch;
`ifdef TDM_GUARD_EN
            w_state_nxt = GUARD;
`else
            w_tmr_start = 1'b1;
`endif
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
`ifdef TDM_GUARD_EN
      GUARD: begin
        w_state_nxt = SLOT;
        w_tmr_start = 1'b1;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase

    // Outputs are derived from the next state so select and data land in one register update
    w_c_nxt     = 1'b1;
    w_sel_nxt   = '0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_ready_nxt = 1'b0;

    case (w_state_nxt)
      SLOT: begin
        w_c_nxt    = w_data_nxt[w_ch_nxt];
        w_sel_nxt  = w_ch_nxt;
        w_busy_nxt = 1'b1;
      end
`ifdef TDM_GUARD_EN
      GUARD: begin
        w_sel_nxt  = w_ch_nxt;
        w_busy_nxt = 1'b1;
      end
`endif
      DONE: begin
        w_done_nxt  = 1'b1;
        w_ready_nxt = 1'b1;
      end
      default: w_ready_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= IDLE;
      r_ch    <= '0;
      r_data  <= '0;
      r_mask  <= '0;
      r_c     <= 1'b1;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_data  <= w_data_nxt;
      r_mask  <= w_mask_nxt;
      r_c     <= w_c_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  assign oReady = r_ready;
  assign oC     = r_c;
  assign oS1    = r_sel[1];
  assign oS0    = r_sel[0];
  assign oBusy  = r_busy;
  assign oDone  = r_done;

endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// tb/tb_tdm_slot_scheduler.sv - directed self-checking bench for tdm_slot_scheduler (HOLD_CYCLES=4)
module tb_tdm_slot_scheduler;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iValid;
  logic       oReady;
  logic [3:0] iData;
  logic [3:0] iMask;
  logic       oC;
  logic       oS1;
  logic       oS0;
  logic       oBusy;
  logic       oDone;

  int checks = 0;
  int errors = 0;

  // Observed bus packed as {oC, oS1, oS0, oBusy, oDone, oReady}
  logic [5:0] obs;
  assign obs = {oC, oS1, oS0, oBusy, oDone, oReady};

  localparam logic [5:0] IDLE_V = 6'b1_00_0_0_1;
  localparam logic [5:0] DONE_V = 6'b1_00_0_1_1;

  always #5 iClk = ~iClk;

  tdm_slot_scheduler #(
    .HOLD_CYCLES(4)
  ) dut (
    .iClk  (iClk),
    .iRst  (iRst),
    .iValid(iValid),
    .oReady(oReady),
    .iData (iData),
    .iMask (iMask),
    .oC    (oC),
    .oS1   (oS1),
    .oS0   (oS0),
    .oBusy (oBusy),
    .oDone (oDone)
  );

  function automatic logic [5:0] slot_v(input logic c, input logic [1:0] ch);
    return {c, ch, 3'b100};
  endfunction

  task automatic test_reset();
    iRst   = 1'b1;
    iValid = 1'b0;
    iData  = 4'h0;
    iMask  = 4'h0;
    repeat (2) @(negedge iClk);
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", obs, IDLE_V);
    end
    iRst = 1'b0;
    @(negedge iClk);
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL reset_idle_hold got=%b exp=%b", obs, IDLE_V);
    end
  endtask

  task automatic test_full_frame();
    logic [3:0] d;
    logic [5:0] exp_v;
    d = 4'b1010;
    @(negedge iClk);
    iValid = 1'b1;
    iData  = d;
    iMask  = 4'b1111;
    @(negedge iClk);
    iValid = 1'b0;
    iData  = 4'b0101;
    iMask  = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge iClk);
      exp_v = slot_v(d[i/4], 2'(i/4));
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL full_frame cyc%0d got=%b exp=%b", i + 1, obs, exp_v);
      end
    end
    @(negedge iClk);
    checks++;
    if (obs !== DONE_V) begin
      errors++;
      $display("FAIL full_frame_done cyc17 got=%b exp=%b", obs, DONE_V);
    end
    @(negedge iClk);
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL full_frame_idle got=%b exp=%b", obs, IDLE_V);
    end
  endtask

  task automatic test_sparse();
    @(negedge iClk);
    iValid = 1'b1;
    iData  = 4'b0000;
    iMask  = 4'b0100;
    @(negedge iClk);
    iData = 4'b1111;
    iMask = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge iClk);
      if (i == 3) iValid = 1'b0;
      checks++;
      if (obs !== slot_v(1'b0, 2'b10)) begin
        errors++;
        $display("FAIL sparse_slot cyc%0d got=%b exp=%b", i + 1, obs, slot_v(1'b0, 2'b10));
      end
    end
    @(negedge iClk);
    checks++;
    if (obs !== DONE_V) begin
      errors++;
      $display("FAIL sparse_done got=%b exp=%b", obs, DONE_V);
    end
    @(negedge iClk);
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL sparse_idle got=%b exp=%b", obs, IDLE_V);
    end
  endtask

  task automatic test_empty();
    @(negedge iClk);
    iValid = 1'b1;
    iData  = 4'b0000;
    iMask  = 4'b0000;
    @(negedge iClk);
    iValid = 1'b0;
    checks++;
    if (obs !== DONE_V) begin
      errors++;
      $display("FAIL empty_done got=%b exp=%b", obs, DONE_V);
    end
    @(negedge iClk);
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL empty_idle got=%b exp=%b", obs, IDLE_V);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_seq [11];
    exp_seq = '{6'b0_00_100, 6'b0_00_100, 6'b0_00_100, 6'b0_00_100, DONE_V,
                6'b1_00_100, 6'b1_00_100, 6'b1_00_100, 6'b1_00_100, DONE_V, IDLE_V};
    @(negedge iClk);
    iValid = 1'b1;
    iData  = 4'b0000;
    iMask  = 4'b0001;
    @(negedge iClk);
    iData = 4'b0001;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge iClk);
      checks++;
      if (obs !== exp_seq[i]) begin
        errors++;
        $display("FAIL back_to_back cyc%0d got=%b exp=%b", i + 1, obs, exp_seq[i]);
      end
      if (i == 5) iValid = 1'b0;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic found;
    found = 1'b0;
    @(negedge iClk);
    iValid = 1'b1;
    iData  = 4'b1101;
    iMask  = 4'b1111;
    @(negedge iClk);
    iValid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (obs === slot_v(1'b0, 2'b01)) begin
        found = 1'b1;
        break;
      end
      @(negedge iClk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_wait_ch1 got=%b exp=%b", obs, slot_v(1'b0, 2'b01));
    end
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL reset_mid_frame got=%b exp=%b", obs, IDLE_V);
    end
    @(negedge iClk);
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL reset_mid_after got=%b exp=%b", obs, IDLE_V);
    end
  endtask

`ifdef TDM_GUARD_EN
  task automatic test_guard();
    logic [5:0] exp_seq [11];
    exp_seq = '{6'b0_00_100, 6'b0_00_100, 6'b0_00_100, 6'b0_00_100, 6'b1_01_100,
                6'b0_01_100, 6'b0_01_100, 6'b0_01_100, 6'b0_01_100, DONE_V, IDLE_V};
    @(negedge iClk);
    iValid = 1'b1;
    iData  = 4'b0000;
    iMask  = 4'b0011;
    @(negedge iClk);
    iValid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge iClk);
      checks++;
      if (obs !== exp_seq[i]) begin
        errors++;
        $display("FAIL guard cyc%0d got=%b exp=%b", i + 1, obs, exp_seq[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef TDM_GUARD_EN
    test_guard();
`else
    test_full_frame();
`endif
    test_sparse();
    test_empty();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule
